fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 16-bit myMIPS core. It owns the program counter, drives the synchronous instruction ROM, and delivers one registered instruction per cycle, with its PC, to the `control` decoder and the regfile address path. It also absorbs downstream stalls without losing the in-flight ROM word, and performs PC redirects for taken `beq`, `j`, `jal` and `jr`, emitting NOP bubbles for the killed slots.

## Interface
- `PC_W`, 12: PC/ROM address width, matching the 12-bit jump address field.
- `RESET_PC`, 0: first fetch address after reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `rom_en` out 1: ROM read strobe for the current cycle.
- `rom_addr` out PC_W: ROM address; driven combinationally from `pc_q`.
- `rom_data` in 16: ROM word; valid the cycle after a cycle with `rom_en`=1, for that cycle's `rom_addr`.
- `stall` in 1: downstream cannot accept; the output stage must hold.
- `redirect` in 1: execute stage requests a PC change.
- `redirect_pc` in PC_W: target address; sampled when `redirect`=1.
- `instr` out 16: registered instruction to decode; NOP (16'h0000) when invalid.
- `instr_valid` out 1: `instr` is a real fetched word.
- `instr_pc` out PC_W: address of `instr`.
- `link_pc` out PC_W: `instr_pc`+1 modulo 2^PC_W, used as the `jal` return value.

## Operation
- FSM states:
  - BOOT: entered on reset; lasts exactly one cycle after `rst` goes high; `rom_en`=0; then goes to RUN.
  - RUN: fetching.
  - HOLD: `stall`=1.
- Transitions:
  - RUN to HOLD when `stall`=1.
  - HOLD to RUN when `stall`=0.
  - `redirect` from any non-BOOT state goes to RUN.
- Issue: in RUN with `stall`=0 and `redirect`=0:
  - `rom_en`=1.
  - `pc_q`<=`pc_q`+1, wrapping 2^PC_W-1 to 0.
  - `infl_v`<=1 and `infl_pc`<=`pc_q`.
  - In any other cycle, `rom_en`=0 and `infl_v`<=0.
- Output stage, when `stall`=0:
  - If `hold_v`: `instr`<=`hold_q`, `instr_pc`<=`hold_pc`, valid<=1, `hold_v`<=0.
  - Else: `instr`<=`infl_v`?`rom_data`:NOP, valid<=`infl_v`, `instr_pc`<=`infl_pc`.
- Stall:
  - Output registers hold their value.
  - If `infl_v`=1 in the stall cycle: `hold_q`<=`rom_data`, `hold_pc`<=`infl_pc`, `hold_v`<=1.
  - No issue while stalled, so one hold entry suffices and no overflow is possible.
- Redirect (priority over `stall`):
  - `pc_q`<=`redirect_pc`.
  - `infl_v`<=0 and `hold_v`<=0.
  - `instr`<=NOP and `instr_valid`<=0.
  - No issue in the redirect cycle.
- Reset values:
  - `pc_q`=RESET_PC.
  - `infl_v`=`hold_v`=0.
  - `instr`=16'h0000, `instr_valid`=0, `instr_pc`=0, `link_pc`=1.
  - `rom_en`=0, state BOOT.
  - Reset mid-operation discards all in-flight and held words.

## Timing
- Fetch latency: issue in cycle k, then `rom_data` in k+1, then `instr` valid in k+2.
- First instruction: `rst` rises before cycle 0.
  - Cycle 0: BOOT.
  - Cycle 1: issue RESET_PC.
  - Cycle 3: `instr`=M[RESET_PC] valid.
- Steady state: one valid instruction per cycle at consecutive PCs.
- Redirect sampled in cycle n:
  - `instr_valid`=0 in n+1 and n+2.
  - `instr`=M[target] valid in n+3.
- Stall high in cycles s..s+m-1:
  - `instr`/`instr_pc`/`instr_valid` constant in s+1..s+m.
  - After release, sequence continues with no gap and no duplicate: held word first, then the next issue.
- `link_pc` tracks `instr_pc` combinationally or as a register; either way it is always consistent with `instr_pc` in the same cycle.

## Structure
- Shared package `mymips_pkg`:
  - `PC_W`.
  - `NOP_INSTR`=16'h0000 (add $r0,$r0,$r0).
  - Opcode constants shared with `control`.
  - Fetch FSM state enum.
- One natural sub-module: `fetch_hold_buf`, the single-entry stall capture register with `hold_q`/`hold_pc`/`hold_v`.

## Test plan
- Reset then free-run, ROM M[i]=16'h1000+i: `instr` = 16'h1000, 16'h1001, … from cycle 3, with `instr_pc` 0,1,2, `link_pc` 1,2,3.
- `stall` for 3 cycles while the word for PC 5 is in flight: output frozen at PC 4 for 3 cycles, then PC 5, 6 with no gap or duplicate.
- `redirect`=1, `redirect_pc`=12'h080 during streaming: exactly two `instr_valid`=0 cycles, then M[0x080] with `instr_pc`=0x080.
- `redirect` and `stall` in the same cycle with `hold_v`=1: held word dropped; next valid instr is M[`redirect_pc`].
- PC wrap with RESET_PC=12'hFFE: `instr_pc` sequence FFE, FFF, 000, 001; `link_pc` at FFF is 000.
- Assert `rst`=0 mid-stall with `hold_v`=1: next cycle `instr_valid`=0 and `rom_en`=0; restart fetches RESET_PC first.

Source files
------------

// File: rtl/mymips_pkg.sv
// rtl/mymips_pkg.sv - shared myMIPS constants, opcodes and fetch FSM states
package mymips_pkg;

  localparam int PC_W = 12;

  // add $r0,$r0,$r0 encodes as all zeros and is the pipeline bubble
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Primary opcode field [15:12], shared with the control decoder
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;
  localparam logic [3:0] OP_JAL   = 4'h6;
  localparam logic [3:0] OP_JR    = 4'h7;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - single-entry capture of the in-flight ROM word during a stall
module fetch_hold_buf #(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_capture,
  input  logic [15:0]     i_data,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_hold_v,
  output logic [15:0]     o_hold_q,
  output logic [PC_W-1:0] o_hold_pc
);
  import mymips_pkg::*;

  logic            r_hold_v;
  logic [15:0]     r_hold_q;
  logic [PC_W-1:0] r_hold_pc;

  // Park the word arriving from the ROM while the output stage is frozen; drain or flush clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_v  <= 1'b0;
      r_hold_q  <= NOP_INSTR;
      r_hold_pc <= '0;
    end else if (i_clear) begin
      r_hold_v  <= 1'b0;
    end else if (i_capture) begin
      r_hold_v  <= 1'b1;
      r_hold_q  <= i_data;
      r_hold_pc <= i_pc;
    end
  end

  assign o_hold_v  = r_hold_v;
  assign o_hold_q  = r_hold_q;
  assign o_hold_pc = r_hold_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - myMIPS instruction fetch: PC, ROM strobe, stall hold and redirect
module fetch_unit #(
  parameter int              PC_W     = mymips_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_en,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] link_pc
);
  import mymips_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic            w_issue;
  logic            w_redir;

  logic [PC_W-1:0] r_pc_q;
  logic            r_infl_v;
  logic [PC_W-1:0] r_infl_pc;

  logic [15:0]     r_instr;
  logic            r_instr_valid;
  logic [PC_W-1:0] r_instr_pc;

  logic            w_hold_v;
  logic [15:0]     w_hold_q;
  logic [PC_W-1:0] w_hold_pc;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_BOOT;
    else      r_state <= w_state_nxt;
  end

  // Next state: BOOT lasts one cycle, redirect wins over stall afterwards
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (redirect)   w_state_nxt = ST_RUN;
        else if (stall) w_state_nxt = ST_HOLD;
        else            w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // FSM outputs: the stall-release cycle in HOLD also issues so the stream resumes without a bubble
  always_comb begin
    w_redir = 1'b0;
    w_issue = 1'b0;
    if (r_state != ST_BOOT) begin
      w_redir = redirect;
      w_issue = !stall && !redirect;
    end
  end

  assign rom_en   = w_issue;
  assign rom_addr = r_pc_q;

  // Program counter and the record of which address the ROM is answering next cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc_q    <= RESET_PC;
      r_infl_v  <= 1'b0;
      r_infl_pc <= '0;
    end else begin
      r_infl_v <= w_issue;
      if (w_redir) begin
        r_pc_q <= redirect_pc;
      end else if (w_issue) begin
        r_pc_q    <= r_pc_q + PC_W'(1);
        r_infl_pc <= r_pc_q;
      end
    end
  end

  fetch_hold_buf #(
    .PC_W (PC_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_redir || !stall),
    .i_capture (stall && r_infl_v),
    .i_data    (rom_data),
    .i_pc      (r_infl_pc),
    .o_hold_v  (w_hold_v),
    .o_hold_q  (w_hold_q),
    .o_hold_pc (w_hold_pc)
  );

  // Output stage: flush on redirect, freeze on stall, otherwise held word before the ROM word
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= '0;
    end else if (w_redir) begin
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
    end else if (!stall) begin
      if (w_hold_v) begin
        r_instr       <= w_hold_q;
        r_instr_valid <= 1'b1;
        r_instr_pc    <= w_hold_pc;
      end else begin
        r_instr       <= r_infl_v ? rom_data : NOP_INSTR;
        r_instr_valid <= r_infl_v;
        r_instr_pc    <= r_infl_pc;
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;
  assign link_pc     = r_instr_pc + PC_W'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue model
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [11:0] redirect_pc;

  logic        rom_en      [2];
  logic [11:0] rom_addr    [2];
  logic [15:0] rom_data    [2];
  logic [15:0] instr       [2];
  logic        instr_valid [2];
  logic [11:0] instr_pc    [2];
  logic [11:0] link_pc     [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  fetch_unit #(.PC_W(12), .RESET_PC(12'h000)) dut0 (
    .clk(clk), .rst(rst), .rom_en(rom_en[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr[0]), .instr_valid(instr_valid[0]), .instr_pc(instr_pc[0]), .link_pc(link_pc[0])
  );

  fetch_unit #(.PC_W(12), .RESET_PC(12'hFFE)) dut1 (
    .clk(clk), .rst(rst), .rom_en(rom_en[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr[1]), .instr_valid(instr_valid[1]), .instr_pc(instr_pc[1]), .link_pc(link_pc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [11:0] a);
    return {4'h1, a};
  endfunction

  function automatic logic [11:0] reset_pc_of(input int i);
    return (i == 0) ? 12'h000 : 12'hFFE;
  endfunction

  // Synchronous ROM; garbage when not strobed so stray use of rom_data shows up
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      rom_data[i] <= rom_en[i] ? rom_word(rom_addr[i]) : 16'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Model: an ordered queue of fetched-but-undelivered addresses per instance
  logic [11:0] m_q     [2][$];
  logic [11:0] m_pc    [2];
  logic [15:0] m_instr [2];
  logic        m_valid [2];
  logic [11:0] m_ipc   [2];
  bit          m_boot  [2];
  bit          m_init = 1'b0;

  always @(posedge clk) begin : model
    logic [11:0] p;
    bit          was_boot;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_q[i].delete();
        m_pc[i]    = reset_pc_of(i);
        m_instr[i] = 16'h0000;
        m_valid[i] = 1'b0;
        m_ipc[i]   = 12'h000;
        m_boot[i]  = 1'b1;
        m_init     = 1'b1;
      end else begin
        was_boot  = m_boot[i];
        m_boot[i] = 1'b0;
        if (!was_boot && redirect) begin
          m_q[i].delete();
          m_pc[i]    = redirect_pc;
          m_instr[i] = 16'h0000;
          m_valid[i] = 1'b0;
        end else if (!stall) begin
          if (m_q[i].size() > 0) begin
            p          = m_q[i].pop_front();
            m_instr[i] = rom_word(p);
            m_valid[i] = 1'b1;
            m_ipc[i]   = p;
          end else begin
            m_instr[i] = 16'h0000;
            m_valid[i] = 1'b0;
          end
          if (!was_boot) begin
            m_q[i].push_back(m_pc[i]);
            m_pc[i] = m_pc[i] + 12'd1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : compare
    logic [11:0] lp;
    logic        exp_en;
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("instr_valid[%0d]", i), 32'(instr_valid[i]), 32'(m_valid[i]));
        chk($sformatf("instr[%0d]", i), 32'(instr[i]), 32'(m_instr[i]));
        if (m_valid[i])
          chk($sformatf("instr_pc[%0d]", i), 32'(instr_pc[i]), 32'(m_ipc[i]));
        lp = instr_pc[i] + 12'd1;
        chk($sformatf("link_pc[%0d]", i), 32'(link_pc[i]), 32'(lp));
        exp_en = !m_boot[i] && !stall && !redirect;
        chk($sformatf("rom_en[%0d]", i), 32'(rom_en[i]), 32'(exp_en));
        if (exp_en)
          chk($sformatf("rom_addr[%0d]", i), 32'(rom_addr[i]), 32'(m_pc[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 12'h000;
    repeat (3) @(posedge clk);
    #3;
    chk("reset instr", 32'(instr[0]), 32'h0000);
    chk("reset valid", 32'(instr_valid[0]), 32'h0);
    chk("reset instr_pc", 32'(instr_pc[0]), 32'h000);
    chk("reset link_pc", 32'(link_pc[0]), 32'h001);
    chk("reset rom_en", 32'(rom_en[0]), 32'h0);
    #1;
    rst = 1'b1;
    cyc = 0;

    for (int c = 1; c <= 40; c++) begin
      step();
      stall       = (c >= 7 && c <= 9) || (c >= 20 && c <= 22) || c == 30 || c == 31;
      redirect    = (c == 14) || (c == 22);
      redirect_pc = (c == 14) ? 12'h080 : 12'h200;
      rst         = !(c == 31 || c == 32);
      #1;
      case (c)
        3: begin
          chk("c3 instr", 32'(instr[0]), 32'h1000);
          chk("c3 pc", 32'(instr_pc[0]), 32'h000);
          chk("c3 link", 32'(link_pc[0]), 32'h001);
          chk("wrap c3 pc", 32'(instr_pc[1]), 32'hFFE);
          chk("wrap c3 instr", 32'(instr[1]), 32'h1FFE);
        end
        4: begin
          chk("c4 instr", 32'(instr[0]), 32'h1001);
          chk("c4 link", 32'(link_pc[0]), 32'h002);
          chk("wrap c4 pc", 32'(instr_pc[1]), 32'hFFF);
          chk("wrap c4 link", 32'(link_pc[1]), 32'h000);
        end
        5: begin
          chk("c5 pc", 32'(instr_pc[0]), 32'h002);
          chk("wrap c5 pc", 32'(instr_pc[1]), 32'h000);
          chk("wrap c5 instr", 32'(instr[1]), 32'h1000);
        end
        6: chk("wrap c6 pc", 32'(instr_pc[1]), 32'h001);
        8, 10: begin
          chk("stall frozen pc", 32'(instr_pc[0]), 32'h004);
          chk("stall frozen instr", 32'(instr[0]), 32'h1004);
          chk("stall frozen valid", 32'(instr_valid[0]), 32'h1);
        end
        11: chk("post-stall held", 32'(instr[0]), 32'h1005);
        12: chk("post-stall next", 32'(instr[0]), 32'h1006);
        15, 16: chk("redirect bubble", 32'(instr_valid[0]), 32'h0);
        17: begin
          chk("redirect target instr", 32'(instr[0]), 32'h1080);
          chk("redirect target pc", 32'(instr_pc[0]), 32'h080);
          chk("redirect target link", 32'(link_pc[0]), 32'h081);
        end
        23, 24: chk("redir+stall bubble", 32'(instr_valid[0]), 32'h0);
        25: begin
          chk("redir+stall instr", 32'(instr[0]), 32'h1200);
          chk("redir+stall pc", 32'(instr_pc[0]), 32'h200);
        end
        32: begin
          chk("mid-stall reset valid", 32'(instr_valid[0]), 32'h0);
          chk("mid-stall reset rom_en", 32'(rom_en[0]), 32'h0);
        end
        34: begin
          chk("restart rom_en", 32'(rom_en[0]), 32'h1);
          chk("restart rom_addr", 32'(rom_addr[0]), 32'h000);
          chk("restart wrap rom_addr", 32'(rom_addr[1]), 32'hFFE);
        end
        36: begin
          chk("restart instr", 32'(instr[0]), 32'h1000);
          chk("restart valid", 32'(instr_valid[0]), 32'h1);
          chk("restart wrap instr", 32'(instr[1]), 32'h1FFE);
        end
        default: ;
      endcase
    end

    for (int c = 0; c < 3000; c++) begin
      step();
      rst         = ($urandom_range(0, 99) != 0);
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = 12'($urandom);
    end

    step();
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
